// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and halt drain control.
// Halt is captured into EX, then three bubble cycles drain the pipe before halted asserts.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ALUSrc,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    input  logic        Halt,
    input  logic [1:0]  ALUOp,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [2:0]  id_funct3,
    input  logic [6:0]  id_funct7,
    input  logic        flush,
    output logic        ex_ALUSrc,
    output logic        ex_MemtoReg,
    output logic        ex_RegWrite,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic        ex_Branch,
    output logic        ex_Halt,
    output logic [1:0]  ex_ALUOp,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rd1,
    output logic [31:0] ex_rd2,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic [6:0]  ex_funct7,
    output logic        stall,
    output logic        halted
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [1:0] drain_cnt;
    logic [1:0] drain_cnt_nxt;
    logic       hazard;
    logic       capture;

    // rs2 is checked for every opcode; spurious stalls on I-type are harmless
    assign hazard = ex_MemRead && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        stall = 1'b0;
        case (state)
            RUN:     stall = hazard && !flush;
            default: stall = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        capture       = 1'b0;
        case (state)
            RUN: begin
                if (!flush && !hazard) begin
                    capture = 1'b1;
                    if (Halt) begin
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = 2'd3;
                    end
                end
            end
            DRAIN: begin
                drain_cnt_nxt = drain_cnt - 2'd1;
                if (drain_cnt == 2'd1) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: ;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            drain_cnt   <= '0;
            halted      <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_Halt     <= 1'b0;
            ex_ALUOp    <= '0;
            ex_pc       <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            halted    <= (state_nxt == HALTED);
            if (capture) begin
                // A Halt enters EX with every other control bit cleared
                ex_ALUSrc   <= ALUSrc   && !Halt;
                ex_MemtoReg <= MemtoReg && !Halt;
                ex_RegWrite <= RegWrite && !Halt;
                ex_MemRead  <= MemRead  && !Halt;
                ex_MemWrite <= MemWrite && !Halt;
                ex_Branch   <= Branch   && !Halt;
                ex_Halt     <= Halt;
                ex_ALUOp    <= Halt ? 2'b00 : ALUOp;
                ex_pc       <= id_pc;
                ex_rd1      <= id_rd1;
                ex_rd2      <= id_rd2;
                ex_imm      <= id_imm;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_rd       <= id_rd;
                ex_funct3   <= id_funct3;
                ex_funct7   <= id_funct7;
            end else begin
                ex_ALUSrc   <= 1'b0;
                ex_MemtoReg <= 1'b0;
                ex_RegWrite <= 1'b0;
                ex_MemRead  <= 1'b0;
                ex_MemWrite <= 1'b0;
                ex_Branch   <= 1'b0;
                ex_Halt     <= 1'b0;
                ex_ALUOp    <= '0;
                ex_pc       <= '0;
                ex_rd1      <= '0;
                ex_rd2      <= '0;
                ex_imm      <= '0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
                ex_rd       <= '0;
                ex_funct3   <= '0;
                ex_funct7   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a cycle-level reference model of the pipeline register.
module tb_id_ex_stage;

    typedef struct packed {
        logic        ALUSrc;
        logic        MemtoReg;
        logic        RegWrite;
        logic        MemRead;
        logic        MemWrite;
        logic        Branch;
        logic        Halt;
        logic [1:0]  ALUOp;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
    } stage_t;

    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   flush = 1'b0;
    stage_t id = '0;
    stage_t obs;
    logic   stall, halted;

    logic ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Halt;
    logic [1:0]  ex_ALUOp;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;

    stage_t m_ex = '0;
    int     m_mode = M_RUN;
    int     m_left = 0;
    logic   m_halted = 1'b0;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ALUSrc(id.ALUSrc), .MemtoReg(id.MemtoReg), .RegWrite(id.RegWrite),
        .MemRead(id.MemRead), .MemWrite(id.MemWrite), .Branch(id.Branch),
        .Halt(id.Halt), .ALUOp(id.ALUOp),
        .id_pc(id.pc), .id_rd1(id.rd1), .id_rd2(id.rd2), .id_imm(id.imm),
        .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
        .id_funct3(id.funct3), .id_funct7(id.funct7), .flush(flush),
        .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
        .ex_Halt(ex_Halt), .ex_ALUOp(ex_ALUOp),
        .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .stall(stall), .halted(halted)
    );

    assign obs = {ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch,
                  ex_Halt, ex_ALUOp, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                  ex_funct3, ex_funct7};

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_stall();
        logic hz;
        hz = m_ex.MemRead && (m_ex.rd != 5'd0) && (m_ex.rd == id.rs1 || m_ex.rd == id.rs2);
        return (m_mode == M_RUN) ? (hz && !flush) : 1'b1;
    endfunction

    task automatic model_edge();
        logic st;
        st = model_stall();
        if (m_mode == M_RUN) begin
            if (flush || st) begin
                m_ex = '0;
            end else begin
                m_ex = id;
                if (id.Halt) begin
                    m_ex.ALUSrc = 0; m_ex.MemtoReg = 0; m_ex.RegWrite = 0;
                    m_ex.MemRead = 0; m_ex.MemWrite = 0; m_ex.Branch = 0;
                    m_ex.ALUOp = 2'b00;
                    m_mode = M_DRAIN;
                    m_left = 3;
                end
            end
        end else begin
            m_ex = '0;
            if (m_mode == M_DRAIN) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = M_HALTED;
                    m_halted = 1'b1;
                end
            end
        end
    endtask

    // Entered just after a falling edge with inputs already driven
    task automatic cycle(input string tag);
        #1 check({tag, ":stall"}, 192'(stall), 192'(model_stall()));
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ":ex"}, 192'(obs), 192'(m_ex));
        check({tag, ":halted"}, 192'(halted), 192'(m_halted));
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        m_ex = '0; m_mode = M_RUN; m_left = 0; m_halted = 1'b0;
        check("rst:ex", 192'(obs), 192'(0));
        check("rst:halted", 192'(halted), 192'(0));
        check("rst:stall", 192'(stall), 192'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_add();
        id = '0; flush = 0;
        id.RegWrite = 1; id.ALUOp = 2'b10; id.rd = 5'd5; id.rd1 = 32'd7;
        id.rs1 = 5'd1; id.rs2 = 5'd2; id.funct7 = 7'h00; id.pc = 32'h40;
    endtask

    task automatic randomize_id();
        id.ALUSrc = 1'($urandom); id.MemtoReg = 1'($urandom); id.RegWrite = 1'($urandom);
        id.MemRead = 1'($urandom); id.MemWrite = 1'($urandom); id.Branch = 1'($urandom);
        id.Halt = ($urandom_range(0, 15) == 0);
        id.ALUOp = 2'($urandom);
        id.pc = $urandom; id.rd1 = $urandom; id.rd2 = $urandom; id.imm = $urandom;
        id.rs1 = 5'($urandom_range(0, 3)); id.rs2 = 5'($urandom_range(0, 3));
        id.rd = 5'($urandom_range(0, 3));
        id.funct3 = 3'($urandom); id.funct7 = 7'($urandom);
        flush = ($urandom_range(0, 4) == 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("por:ex", 192'(obs), 192'(0));
        check("por:halted", 192'(halted), 192'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // R-type add captured with latency 1
        set_add();
        cycle("add");
        check("add:rd", 192'(ex_rd), 192'(5));
        check("add:rd1", 192'(ex_rd1), 192'(7));
        check("add:aluop", 192'(ex_ALUOp), 192'(2));

        // Load to x3, then a consumer of x3 must stall and bubble
        id = '0; id.MemRead = 1; id.MemtoReg = 1; id.RegWrite = 1; id.ALUSrc = 1; id.rd = 5'd3;
        cycle("lw3");
        id = '0; id.RegWrite = 1; id.ALUOp = 2'b10; id.rs1 = 5'd3; id.rd = 5'd4;
        cycle("use3");
        check("use3:ctl", 192'({ex_RegWrite, ex_MemRead, ex_ALUOp}), 192'(0));
        // Load to x0 never causes a stall
        id = '0; id.MemRead = 1; id.RegWrite = 1; id.rd = 5'd0;
        cycle("lw0");
        id = '0; id.RegWrite = 1; id.rs1 = 5'd0; id.rs2 = 5'd0; id.rd = 5'd6;
        cycle("use0");

        // Flush beats hazard and Halt
        id = '0; id.MemRead = 1; id.rd = 5'd9;
        cycle("lw9");
        id = '0; id.Halt = 1; id.rs2 = 5'd9; flush = 1;
        cycle("fl_halt");
        set_add();
        cycle("after_fl");

        // Halt drains three cycles, flush ignored meanwhile
        id = '0; id.Halt = 1; id.RegWrite = 1; id.MemWrite = 1; id.rd = 5'd7;
        cycle("halt");
        check("halt:exhalt", 192'(ex_Halt), 192'(1));
        for (int i = 0; i < 5; i++) begin
            set_add(); flush = 1'(i);
            cycle("drain");
        end
        check("halted_now", 192'(halted), 192'(1));

        do_reset();
        set_add();
        cycle("post_rst");

        // Reset asserted in the middle of DRAIN abandons the drain
        id = '0; id.Halt = 1;
        cycle("halt2");
        set_add();
        cycle("drain2");
        do_reset();
        set_add();
        cycle("post_rst2");
        check("post_rst2:rw", 192'(ex_RegWrite), 192'(1));

        for (int n = 0; n < 400; n++) begin
            if (m_mode == M_HALTED && $urandom_range(0, 3) == 0) do_reset();
            randomize_id();
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
